// File: rtl/spram_banked_pkg.sv
// Shared types and helpers for the banked single-port SRAM.
// Holds the clear/ready FSM encoding and an integer clog2 helper.
package spram_banked_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/spram_bank.sv
// One SRAM bank: DW x ROWS, per-byte write, registered read on cs.
// Ports: clk, cs, we, be, addr, wdata -> rdata (valid one cycle after a read).
module spram_bank #(
  parameter int DW   = 64,
  parameter int ROWS = 128,
  parameter int RW   = 7
) (
  input  logic            clk,
  input  logic            cs,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [RW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        for (int i = 0; i < DW/8; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/spram_banked.sv
// Banked single-port SRAM with valid/ready requests, byte enables,
// fixed read latency N_DELAY and optional zero-fill after reset.
// Ports: clk, rst, req_{valid,ready,we,be,addr,wdata}, rsp_{valid,data}, busy.
module spram_banked
  import spram_banked_pkg::*;
#(
  parameter int DW           = 64,
  parameter int DEPTH        = 256,
  parameter int NBANK        = 2,
  parameter int N_DELAY      = 1,
  parameter int CLEAR_ON_RST = 1,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [DW/8-1:0] req_be,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            busy
);

  localparam int LB   = clog2(NBANK);
  localparam int BW   = (NBANK > 1) ? LB : 1;
  localparam int ROWS = DEPTH / NBANK;
  localparam int RW   = (AW - LB > 0) ? AW - LB : 1;
  localparam int NB   = DW / 8;

  state_e        st_q, st_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          clearing;
  logic          acc, acc_rd;
  logic [BW-1:0] bank;
  logic [RW-1:0] row;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      ST_CLEAR: begin
        if (cnt_q == RW'(ROWS - 1)) st_d = ST_READY;
        else cnt_d = cnt_q + 1'b1;
      end
      default: st_d = ST_READY;
    endcase
  end

  // Outputs are gated by rst so they read idle during the reset cycle itself.
  assign clearing  = (st_q == ST_CLEAR) && !rst;
  assign busy      = clearing;
  assign req_ready = (st_q == ST_READY) && !rst;
  assign acc       = req_valid && req_ready;
  assign acc_rd    = acc && !req_we;

  assign bank = (NBANK > 1) ? BW'(req_addr) : '0;
  assign row  = RW'(req_addr >> LB);

  logic [NBANK-1:0] cs;
  logic             b_we;
  logic [NB-1:0]    b_be;
  logic [RW-1:0]    b_addr;
  logic [DW-1:0]    b_wdata;
  logic [DW-1:0]    rdata [NBANK];

  // Clear drives every bank with the row counter; normal ops hit one bank.
  always_comb begin
    cs = '0;
    for (int b = 0; b < NBANK; b++) begin
      cs[b] = clearing || (acc && (bank == BW'(b)));
    end
  end

  assign b_we    = clearing || req_we;
  assign b_be    = clearing ? '1 : req_be;
  assign b_addr  = clearing ? cnt_q : row;
  assign b_wdata = clearing ? '0 : req_wdata;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    spram_bank #(
      .DW   (DW),
      .ROWS (ROWS),
      .RW   (RW)
    ) u_bank (
      .clk   (clk),
      .cs    (cs[b]),
      .we    (b_we),
      .be    (b_be),
      .addr  (b_addr),
      .wdata (b_wdata),
      .rdata (rdata[b])
    );
  end

  // First stage: bank output is live, pick it with the bank that rode along.
  logic          pv0;
  logic [BW-1:0] bsel_q;
  logic [DW-1:0] d0;
  logic          out_v;
  logic [DW-1:0] out_d;
  logic [DW-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) pv0 <= 1'b0;
    else pv0 <= acc_rd;
    if (acc_rd) bsel_q <= bank;
  end

  assign d0 = rdata[bsel_q];

  if (N_DELAY == 1) begin : g_nodly
    assign out_v = pv0;
    assign out_d = d0;
  end else begin : g_dly
    logic [N_DELAY-2:0] v_q;
    logic [DW-1:0]      d_q [N_DELAY-1];

    always_ff @(posedge clk) begin
      if (rst) v_q <= '0;
      else v_q <= {v_q[N_DELAY-2:0], pv0} >> 0;
      d_q[0] <= d0;
      for (int k = 1; k < N_DELAY - 1; k++) d_q[k] <= d_q[k-1];
    end

    assign out_v = v_q[N_DELAY-2];
    assign out_d = d_q[N_DELAY-2];
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else if (out_v) hold_q <= out_d;
  end

  assign rsp_valid = out_v && !rst;
  assign rsp_data  = rst ? '0 : (out_v ? out_d : hold_q);

endmodule
